// File: rtl/hack_isa_pkg.sv
// Hack ISA definitions shared by the program loader back-end and the CPU
// instruction decoder: opcode prefixes, field positions, legal comp codes
// and the loader session states.
package hack_isa_pkg;

  localparam logic       OP_A = 1'b0;
  localparam logic [2:0] OP_C = 3'b111;

  localparam int PREFIX_HI = 15;
  localparam int PREFIX_LO = 13;
  localparam int A_POS     = 12;
  localparam int COMP_HI   = 11;
  localparam int COMP_LO   = 6;
  localparam int DEST_HI   = 5;
  localparam int DEST_LO   = 3;
  localparam int JUMP_HI   = 2;
  localparam int JUMP_LO   = 0;

  // Legal comp codes {zx,nx,zy,ny,f,no}; the a-bit selects A or M separately.
  localparam logic [5:0] COMP_ZERO       = 6'b101010;
  localparam logic [5:0] COMP_ONE        = 6'b111111;
  localparam logic [5:0] COMP_NEG_ONE    = 6'b111010;
  localparam logic [5:0] COMP_D          = 6'b001100;
  localparam logic [5:0] COMP_AM         = 6'b110000;
  localparam logic [5:0] COMP_NOT_D      = 6'b001101;
  localparam logic [5:0] COMP_NOT_AM     = 6'b110001;
  localparam logic [5:0] COMP_NEG_D      = 6'b001111;
  localparam logic [5:0] COMP_NEG_AM     = 6'b110011;
  localparam logic [5:0] COMP_D_PLUS_1   = 6'b011111;
  localparam logic [5:0] COMP_AM_PLUS_1  = 6'b110111;
  localparam logic [5:0] COMP_D_MINUS_1  = 6'b001110;
  localparam logic [5:0] COMP_AM_MINUS_1 = 6'b110010;
  localparam logic [5:0] COMP_D_PLUS_AM  = 6'b000010;
  localparam logic [5:0] COMP_D_MINUS_AM = 6'b010011;
  localparam logic [5:0] COMP_AM_MINUS_D = 6'b000111;
  localparam logic [5:0] COMP_D_AND_AM   = 6'b000000;
  localparam logic [5:0] COMP_D_OR_AM    = 6'b010101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } load_state_e;

  function automatic logic [15:0] encode_a(input logic [14:0] value);
    return {OP_A, value};
  endfunction

  function automatic logic [15:0] encode_c(input logic       a_or_m,
                                           input logic [5:0] comp,
                                           input logic [2:0] dest,
                                           input logic [2:0] jump);
    logic [15:0] word;
    word                     = '0;
    word[PREFIX_HI:PREFIX_LO] = OP_C;
    word[A_POS]              = a_or_m;
    word[COMP_HI:COMP_LO]    = comp;
    word[DEST_HI:DEST_LO]    = dest;
    word[JUMP_HI:JUMP_LO]    = jump;
    return word;
  endfunction

endpackage

// File: rtl/hack_comp_checker.sv
// Flags whether a C-instruction comp field is one of the 18 ALU operations
// the Hack CPU implements.
module hack_comp_checker
  import hack_isa_pkg::*;
(
  input  logic [5:0] comp,
  output logic       legal
);

  // Match the comp field against the legal operation set.
  always_comb begin
    legal = 1'b0;
    case (comp)
      COMP_ZERO, COMP_ONE, COMP_NEG_ONE, COMP_D, COMP_AM, COMP_NOT_D,
      COMP_NOT_AM, COMP_NEG_D, COMP_NEG_AM, COMP_D_PLUS_1, COMP_AM_PLUS_1,
      COMP_D_MINUS_1, COMP_AM_MINUS_1, COMP_D_PLUS_AM, COMP_D_MINUS_AM,
      COMP_AM_MINUS_D, COMP_D_AND_AM, COMP_D_OR_AM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/hack_instruction_encoder.sv
// Program-loader back-end: packs field-level Hack instruction requests into
// 16-bit words and writes them to consecutive instruction-ROM addresses
// within a start/finish framed session.
module hack_instruction_encoder
  import hack_isa_pkg::*;
#(
  parameter int ADDR_W    = 15,
  parameter int ROM_DEPTH = 32768,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_a,
  input  logic [14:0]       in_value,
  input  logic              in_a_or_m,
  input  logic [5:0]        in_comp,
  input  logic [2:0]        in_dest,
  input  logic [2:0]        in_jump,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_data,
  output logic              busy,
  output logic [ADDR_W:0]   word_count,
  output logic              err_illegal,
  output logic              err_overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  load_state_e       state;
  load_state_e       state_next;
  logic              legal_p0;
  logic              accept_p0;
  logic              vld_p0;
  logic [15:0]       enc_p0;
  logic              addr_step;
  logic [ADDR_W-1:0] wr_addr_p0;

  hack_comp_checker u_comp_checker (
    .comp  (in_comp),
    .legal (legal_p0)
  );

  // p0: request handshake, legality and encoding (combinational)
  assign accept_p0 = in_valid && in_ready;
  assign vld_p0    = accept_p0 && (state == ST_LOAD) && (in_is_a || legal_p0);
  assign enc_p0    = in_is_a ? encode_a(in_value)
                             : encode_c(in_a_or_m, in_comp, in_dest, in_jump);

  // rom_addr shows the address of the word being strobed and only moves on
  // the cycle after the strobe, so the next write's address is one ahead of
  // it while a strobe is in flight. It never moves past the last ROM word.
  assign addr_step  = rom_we && (rom_addr != LAST_ADDR);
  assign wr_addr_p0 = addr_step ? rom_addr + 1'b1 : rom_addr;

  assign busy = (state != ST_IDLE);

  // Session state register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Session transitions and request-side ready; finish blocks a same-cycle request.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = !finish;
        if (finish)                                    state_next = ST_DRAIN;
        else if (vld_p0 && (wr_addr_p0 == LAST_ADDR))  state_next = ST_FULL;
      end
      ST_FULL: begin
        in_ready = !finish;
        if (finish) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // p1: registered ROM write port, word counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_we       <= 1'b0;
      rom_addr     <= BASE;
      rom_data     <= '0;
      word_count   <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      rom_we <= vld_p0;
      if ((state == ST_IDLE) && start) begin
        rom_addr     <= BASE;
        word_count   <= '0;
        err_illegal  <= 1'b0;
        err_overflow <= 1'b0;
      end else begin
        if (addr_step) rom_addr <= rom_addr + 1'b1;
        if (vld_p0) begin
          rom_data   <= enc_p0;
          word_count <= word_count + 1'b1;
        end
        if (accept_p0 && (state == ST_LOAD) && !in_is_a && !legal_p0)
          err_illegal <= 1'b1;
        if (accept_p0 && (state == ST_FULL))
          err_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hack_instruction_encoder.sv
// Bench for hack_instruction_encoder: a session-level reference model checked
// against the DUT every cycle, plus directed vectors with literal expectations.
module tb_hack_instruction_encoder;

  localparam int ADDR_W    = 15;
  localparam int ROM_DEPTH = 4;
  localparam int BASE_ADDR = 0;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              finish = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_is_a = 1'b0;
  logic [14:0]       in_value = '0;
  logic              in_a_or_m = 1'b0;
  logic [5:0]        in_comp = '0;
  logic [2:0]        in_dest = '0;
  logic [2:0]        in_jump = '0;
  logic              in_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;
  logic              busy;
  logic [ADDR_W:0]   word_count;
  logic              err_illegal;
  logic              err_overflow;

  int checks = 0;
  int errors = 0;
  bit run_cmp = 1'b0;

  always #5 clk = ~clk;

  hack_instruction_encoder #(
    .ADDR_W    (ADDR_W),
    .ROM_DEPTH (ROM_DEPTH),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .finish       (finish),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_is_a      (in_is_a),
    .in_value     (in_value),
    .in_a_or_m    (in_a_or_m),
    .in_comp      (in_comp),
    .in_dest      (in_dest),
    .in_jump      (in_jump),
    .rom_we       (rom_we),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .busy         (busy),
    .word_count   (word_count),
    .err_illegal  (err_illegal),
    .err_overflow (err_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The ALU operations the Hack CPU defines: 0 1 -1 D A !D !A -D -A D+1 A+1
  // D-1 A-1 D+A D-A A-D D&A D|A (A may be M via the a-bit).
  localparam logic [5:0] LEGAL_LIST [18] = '{
    6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
    6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
    6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

  function automatic bit comp_ok(input logic [5:0] c);
    for (int k = 0; k < 18; k++) if (LEGAL_LIST[k] == c) return 1'b1;
    return 1'b0;
  endfunction

  bit          m_open = 0, m_full = 0, m_drain = 0, m_ill = 0, m_ovf = 0;
  int          m_addr = BASE_ADDR, m_count = 0;
  bit          exp_we = 0;
  int          exp_addr = 0;
  logic [15:0] exp_data = '0;

  // Session model: what must be written at the next cycle given this cycle's inputs.
  always @(posedge clk) begin
    if (reset) begin
      m_open = 0; m_full = 0; m_drain = 0; m_ill = 0; m_ovf = 0;
      m_addr = BASE_ADDR; m_count = 0; exp_we = 0; exp_data = '0;
    end else begin
      exp_we = 0;
      if (m_drain) m_drain = 0;
      else if (!m_open) begin
        if (start) begin
          m_open = 1; m_full = 0; m_addr = BASE_ADDR; m_count = 0; m_ill = 0; m_ovf = 0;
        end
      end else if (finish) begin
        m_open = 0; m_drain = 1;
      end else if (in_valid) begin
        if (m_full) m_ovf = 1;
        else if (!in_is_a && !comp_ok(in_comp)) m_ill = 1;
        else begin
          exp_we   = 1;
          exp_addr = m_addr;
          exp_data = in_is_a ? 16'(in_value)
                             : 16'hE000 + 16'(in_a_or_m) * 16'h1000 + 16'(in_comp) * 16'd64
                               + 16'(in_dest) * 16'd8 + 16'(in_jump);
          m_count++;
          if (m_addr == ROM_DEPTH - 1) m_full = 1;
          else m_addr++;
        end
      end
    end
  end

  // Compare process, away from the active edge.
  always @(negedge clk) begin
    if (run_cmp) begin
      check("busy", busy, m_open || m_drain);
      check("in_ready", in_ready, m_open && !finish);
      check("rom_we", rom_we, exp_we);
      if (exp_we) check("rom_addr", rom_addr, exp_addr);
      check("rom_data", rom_data, exp_data);
      check("word_count", word_count, m_count);
      check("err_illegal", err_illegal, m_ill);
      check("err_overflow", err_overflow, m_ovf);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_a(input logic [14:0] v);
    in_is_a = 1'b1; in_value = v;
  endtask

  task automatic set_c(input logic a, input logic [5:0] c, input logic [2:0] d, input logic [2:0] j);
    in_is_a = 1'b0; in_a_or_m = a; in_comp = c; in_dest = d; in_jump = j;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic send_one();
    in_valid = 1'b1; cyc(); in_valid = 1'b0;
  endtask

  task automatic end_session();
    finish = 1'b1; cyc(); finish = 1'b0;
    @(negedge clk); check("drain_busy", busy, 1);
    cyc();
    @(negedge clk); check("idle_busy", busy, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout at t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) cyc();
    @(negedge clk);
    check("rst_we", rom_we, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_addr", rom_addr, BASE_ADDR);
    check("rst_data", rom_data, 0);
    check("rst_count", word_count, 0);
    check("rst_errs", {err_illegal, err_overflow}, 0);
    run_cmp = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();

    // finish in IDLE is ignored
    finish = 1'b1; cyc(); finish = 1'b0; cyc();

    // A-instruction 0x1234
    pulse_start();
    set_a(15'h1234); send_one();
    @(negedge clk);
    check("a_we", rom_we, 1); check("a_addr", rom_addr, 0);
    check("a_data", rom_data, 16'h1234); check("a_count", word_count, 1);
    end_session();

    // D=M+1, plus a request colliding with finish
    pulse_start();
    set_c(1'b1, 6'b110111, 3'b010, 3'b000); send_one();
    @(negedge clk);
    check("c_data", rom_data, 16'hFDD0); check("c_addr", rom_addr, 0);
    start = 1'b1;                             // ignored inside a session
    set_c(1'b0, 6'b000010, 3'b011, 3'b111); in_valid = 1'b1; finish = 1'b1;
    cyc();
    start = 1'b0; in_valid = 1'b0; finish = 1'b0;
    @(negedge clk);
    check("finish_wins_we", rom_we, 0); check("finish_wins_count", word_count, 1);
    cyc(); cyc();

    // four back-to-back requests, no bubbles
    pulse_start();
    set_a(15'd100); in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      set_c(i[0], (i == 1) ? 6'b010101 : 6'b001111, i[2:0], 3'b101);
      @(negedge clk);
      check("b2b_we", rom_we, 1); check("b2b_addr", rom_addr, i);
    end
    in_valid = 1'b0;
    check("b2b_count", word_count, 4);
    end_session();

    // illegal comp code then a legal word at the unchanged address
    pulse_start();
    set_c(1'b0, 6'b101011, 3'b001, 3'b000); send_one();
    @(negedge clk);
    check("ill_we", rom_we, 0); check("ill_flag", err_illegal, 1);
    set_a(15'h0042); send_one();
    @(negedge clk);
    check("ill_next_we", rom_we, 1); check("ill_next_addr", rom_addr, 0);
    check("ill_next_data", rom_data, 16'h0042); check("ill_sticky", err_illegal, 1);
    end_session();

    // overflow: five requests into a four-word ROM
    pulse_start();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) set_c(1'b1, 6'b000000, 3'b100, 3'b010);
      else        set_a(15'(i * 7 + 1));
      cyc();
      @(negedge clk);
      check("ovf_we", rom_we, (i < 4) ? 1 : 0);
    end
    in_valid = 1'b0;
    check("ovf_flag", err_overflow, 1); check("ovf_count", word_count, 4);
    check("ovf_addr_hold", rom_addr, ROM_DEPTH - 1); check("ovf_illegal", err_illegal, 0);
    end_session();
    check("idle_count_hold", word_count, 4);

    // reset mid-LOAD at address 2
    pulse_start();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_a(15'(16'h0300 + i));
      cyc();
    end
    @(negedge clk);
    check("pre_rst_addr", rom_addr, 2);
    reset = 1'b1; in_valid = 1'b0;
    cyc();
    @(negedge clk);
    check("mid_rst_we", rom_we, 0); check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", rom_addr, BASE_ADDR); check("mid_rst_data", rom_data, 0);
    check("mid_rst_count", word_count, 0);
    reset = 1'b0;
    cyc();
    pulse_start();
    set_a(15'h0007); send_one();
    @(negedge clk);
    check("post_rst_addr", rom_addr, BASE_ADDR); check("post_rst_data", rom_data, 16'h0007);
    end_session();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
